// File: rtl/fully_pipelined_subtractor_if.sv
// Streaming handshake bundle for fully_pipelined_subtractor.
// Port ovf exists only when FULLY_PIPELINED_SUBTRACTOR_OVF_EN is defined.
interface fully_pipelined_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef FULLY_PIPELINED_SUBTRACTOR_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
`ifdef FULLY_PIPELINED_SUBTRACTOR_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, d, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
`ifdef FULLY_PIPELINED_SUBTRACTOR_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, d, bout
  );
endinterface

// File: rtl/fully_pipelined_subtractor.sv
// Bit-serial-in-space ripple-borrow subtractor: one borrow bit resolved per stage,
// global stall handshake. Optional signed overflow via FULLY_PIPELINED_SUBTRACTOR_OVF_EN.
module fully_pipelined_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input logic                          clk,
  input logic                          rst,
  fully_pipelined_subtractor_if.slave  bus
);

  // Stage index 0 is the input register, WIDTH is the output register.
  logic [WIDTH:0]            vld;
  logic [WIDTH:0]            br;
  logic [WIDTH:0][WIDTH-1:0] x;
  logic [WIDTH:1][WIDTH-1:0] x_nxt;
  logic [WIDTH:1]            br_nxt;
  logic                      adv;

  assign adv           = ~(vld[WIDTH] & ~bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld[WIDTH];
  assign bus.d         = x[WIDTH];
  assign bus.bout      = br[WIDTH];

  // Subtrahend bits shrink by one per stage: stage j keeps only bits [WIDTH-1:j].
  for (genvar j = 0; j < WIDTH; j++) begin : g_b
    logic [WIDTH-1:j] q;
    if (j == 0) begin : g_in
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (adv) q <= bus.b;
      end
    end else begin : g_mid
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (adv) q <= g_b[j-1].q[WIDTH-1:j];
      end
    end
  end

  for (genvar k = 1; k <= WIDTH; k++) begin : g_bit
    localparam int unsigned I = k - 1;
    localparam logic [WIDTH-1:0] BIT_MASK = WIDTH'(1) << I;
    logic a_bit;
    logic b_bit;
    logic d_bit;

    assign a_bit     = x[k-1][I];
    assign b_bit     = g_b[k-1].q[I];
    assign d_bit     = a_bit ^ b_bit ^ br[k-1];
    assign br_nxt[k] = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br[k-1]);
    assign x_nxt[k]  = (x[k-1] & ~BIT_MASK) | ({WIDTH{d_bit}} & BIT_MASK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      br  <= '0;
      x   <= '0;
    end else if (adv) begin
      vld <= {vld[WIDTH-1:0], bus.in_valid};
      br  <= {br_nxt, bus.bin};
      x   <= {x_nxt, bus.a};
    end
  end

`ifdef FULLY_PIPELINED_SUBTRACTOR_OVF_EN
  // Operand sign bits ride alongside; x loses a's sign once the top bit resolves.
  logic [WIDTH:0] sa;
  logic [WIDTH:0] sb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
    end else if (adv) begin
      sa <= {sa[WIDTH-1:0], bus.a[WIDTH-1]};
      sb <= {sb[WIDTH-1:0], bus.b[WIDTH-1]};
    end
  end

  assign bus.ovf = (sa[WIDTH] != sb[WIDTH]) & (x[WIDTH][WIDTH-1] != sa[WIDTH]);
`endif

endmodule

// File: tb/tb_fully_pipelined_subtractor.sv
// Scoreboard bench for fully_pipelined_subtractor: randomized and directed stimulus
// against an arithmetic reference model, including latency, stall hold and reset.
module tb_fully_pipelined_subtractor;
  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 1 << W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fully_pipelined_subtractor_if #(.WIDTH(W)) bus();
  fully_pipelined_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    int unsigned  acc_cyc;
    int unsigned  acc_stall;
  } exp_t;

  exp_t        q[$];
  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned cyc = 0;
  int unsigned stall_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic exp_t model(input int unsigned av, input int unsigned bv, input int unsigned binv);
    exp_t e;
    int   diff;
    int   sa;
    int   sb;
    int   sr;
    diff   = int'(av) - int'(bv) - int'(binv);
    e.d    = W'((diff + 2 * int'(MOD)) % int'(MOD));
    e.bout = (av < bv + binv);
    sa     = (av >= MOD / 2) ? int'(av) - int'(MOD) : int'(av);
    sb     = (bv >= MOD / 2) ? int'(bv) - int'(MOD) : int'(bv);
    sr     = sa - sb - int'(binv);
    e.ovf  = (sr < -int'(MOD / 2)) || (sr > int'(MOD / 2) - 1);
    e.acc_cyc   = 0;
    e.acc_stall = 0;
    return e;
  endfunction

  // Monitor: evaluates each cycle after inputs settle, predicting the coming edge.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_d;
  logic         prev_bout;
  logic         prev_ovf;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst) begin
        q.delete();
        prev_stall = 1'b0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_d", bus.d, 0);
        check("rst_bout", bus.bout, 0);
`ifdef FULLY_PIPELINED_SUBTRACTOR_OVF_EN
        check("rst_ovf", bus.ovf, 0);
`endif
      end else begin
        check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
        if (prev_stall) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_d", bus.d, prev_d);
          check("hold_bout", bus.bout, prev_bout);
`ifdef FULLY_PIPELINED_SUBTRACTOR_OVF_EN
          check("hold_ovf", bus.ovf, prev_ovf);
`endif
        end
        if (bus.out_valid && !bus.out_ready) stall_total++;
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            check("spurious_out_valid", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("d", bus.d, e.d);
            check("bout", bus.bout, e.bout);
`ifdef FULLY_PIPELINED_SUBTRACTOR_OVF_EN
            check("ovf", bus.ovf, e.ovf);
`endif
            check("latency", cyc, e.acc_cyc + W + 1 + (stall_total - e.acc_stall));
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_t e;
          e = model(bus.a, bus.b, bus.bin);
          e.acc_cyc   = cyc;
          e.acc_stall = stall_total;
          q.push_back(e);
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_d     = bus.d;
        prev_bout  = bus.bout;
`ifdef FULLY_PIPELINED_SUBTRACTOR_OVF_EN
        prev_ovf   = bus.ovf;
`else
        prev_ovf   = 1'b0;
`endif
      end
    end
  end

  task automatic drive(input logic v, input int unsigned av, input int unsigned bv, input int unsigned binv);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = W'(av);
    bus.b        = W'(bv);
    bus.bin      = 1'(binv);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    drive(1'b1, 9, 3, 0);
    idle(7);
    drive(1'b1, 3, 9, 0);
    drive(1'b1, 0, 0, 1);
    idle(7);

    for (int unsigned i = 0; i < 16; i++) drive(1'b1, i, 15 - i, 0);
    idle(7);

    drive(1'b1, 8, 1, 0);
    drive(1'b1, 7, 1, 0);
    idle(7);

    // Three-cycle downstream stall while results are presented
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, $urandom_range(MOD - 1), $urandom_range(MOD - 1), $urandom_range(1));
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_setup_out_valid", seen, 1);
    bus.out_ready = 1'b0;
    repeat (2) drive(1'b1, $urandom_range(MOD - 1), $urandom_range(MOD - 1), $urandom_range(1));
    @(negedge clk);
    bus.out_ready = 1'b1;
    idle(10);

    // Reset with samples in flight
    drive(1'b1, 11, 4, 0);
    drive(1'b1, 2, 13, 1);
    drive(1'b1, 6, 6, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5, 2, 1);
    idle(8);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom_range(MOD - 1), $urandom_range(MOD - 1), $urandom_range(1));
      bus.out_ready = (($urandom % 4) != 0);
    end

    bus.out_ready = 1'b1;
    idle(1);
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    #3;
    check("drain_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
